// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: decodes the ID opcode and carries EX/M/WB control
// through ID/EX, EX/MEM and MEM/WB, with load-use stalls, branch/jump flushes and event counters.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int EXT_OPS    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            op,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  jump,
  output logic                  illegal,
  output logic [1:0]            idex_ex,
  output logic [2:0]            idex_aluop,
  output logic [3:0]            idex_m,
  output logic [1:0]            idex_wb,
  output logic [REG_ADDR_W-1:0] idex_rt,
  output logic [3:0]            exmem_m,
  output logic [1:0]            exmem_wb,
  output logic [1:0]            memwb_wb,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam bit              EXT_EN  = (EXT_OPS != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            dec_ex_s, idex_ex_q, idex_ex_d;
  logic [2:0]            dec_alu_s, idex_alu_q, idex_alu_d;
  logic [3:0]            dec_m_s, idex_m_q, idex_m_d, exmem_m_q, exmem_m_d;
  logic [1:0]            dec_wb_s, idex_wb_q, idex_wb_d, exmem_wb_q, exmem_wb_d;
  logic [1:0]            memwb_wb_q, memwb_wb_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                  known_s, uses_rt_s, is_j_s, carry_s, hz_s;

  // Opcode decode; an invalid slot decodes to an all-zero bubble
  always_comb begin
    dec_ex_s  = 2'b00;
    dec_alu_s = 3'b000;
    dec_m_s   = 4'b0000;
    dec_wb_s  = 2'b00;
    known_s   = 1'b0;
    uses_rt_s = 1'b0;
    is_j_s    = 1'b0;
    if (id_valid) begin
      case (op)
        6'b000000: begin dec_ex_s = 2'b10; dec_alu_s = 3'b010; dec_wb_s = 2'b01; known_s = 1'b1; uses_rt_s = 1'b1; end
        6'b100011: begin dec_ex_s = 2'b01; dec_m_s = 4'b0010; dec_wb_s = 2'b11; known_s = 1'b1; end
        6'b101011: begin dec_ex_s = 2'b01; dec_m_s = 4'b0001; known_s = 1'b1; uses_rt_s = 1'b1; end
        6'b001000: begin dec_ex_s = 2'b01; dec_wb_s = 2'b01; known_s = 1'b1; end
        6'b000100: begin dec_alu_s = 3'b001; dec_m_s = 4'b0100; known_s = 1'b1; uses_rt_s = 1'b1; end
        6'b000010: begin known_s = 1'b1; is_j_s = 1'b1; end
        6'b001100: if (EXT_EN) begin dec_ex_s = 2'b01; dec_alu_s = 3'b011; dec_wb_s = 2'b01; known_s = 1'b1; end
                   else begin known_s = 1'b0; end
        6'b001101: if (EXT_EN) begin dec_ex_s = 2'b01; dec_alu_s = 3'b100; dec_wb_s = 2'b01; known_s = 1'b1; end
                   else begin known_s = 1'b0; end
        6'b001010: if (EXT_EN) begin dec_ex_s = 2'b01; dec_alu_s = 3'b101; dec_wb_s = 2'b01; known_s = 1'b1; end
                   else begin known_s = 1'b0; end
        6'b000101: if (EXT_EN) begin dec_alu_s = 3'b001; dec_m_s = 4'b1000; known_s = 1'b1; uses_rt_s = 1'b1; end
                   else begin known_s = 1'b0; end
        default:   known_s = 1'b0;
      endcase
    end else begin
      known_s = 1'b0;
    end
  end

  // rt only follows instructions that actually occupy the EX slot
  assign carry_s = id_valid & known_s & ~is_j_s;
  assign hz_s    = idex_m_q[1] && (idex_rt_q != '0) && id_valid &&
                   ((idex_rt_q == id_rs) || (uses_rt_s && (idex_rt_q == id_rt)));
  assign jump    = id_valid && (op == 6'b000010);
  assign stall   = ~rst & ~branch_taken & hz_s;
  assign flush   = ~rst & (branch_taken | (~hz_s & jump));

  // Next-state for pipeline control registers, illegal pulse and counters
  always_comb begin
    idex_ex_d   = dec_ex_s;
    idex_alu_d  = dec_alu_s;
    idex_m_d    = dec_m_s;
    idex_wb_d   = dec_wb_s;
    idex_rt_d   = carry_s ? id_rt : '0;
    exmem_m_d   = idex_m_q;
    exmem_wb_d  = idex_wb_q;
    memwb_wb_d  = exmem_wb_q;
    illegal_d   = id_valid & ~known_s & ~branch_taken & ~hz_s;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken || hz_s) begin
      idex_ex_d  = 2'b00;
      idex_alu_d = 3'b000;
      idex_m_d   = 4'b0000;
      idex_wb_d  = 2'b00;
      idex_rt_d  = '0;
    end else begin
      idex_rt_d = carry_s ? id_rt : '0;
    end
    if (branch_taken) begin
      exmem_m_d  = 4'b0000;
      exmem_wb_d = 2'b00;
    end else begin
      exmem_m_d  = idex_m_q;
    end
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex_q   <= 2'b00;
      idex_alu_q  <= 3'b000;
      idex_m_q    <= 4'b0000;
      idex_wb_q   <= 2'b00;
      idex_rt_q   <= '0;
      exmem_m_q   <= 4'b0000;
      exmem_wb_q  <= 2'b00;
      memwb_wb_q  <= 2'b00;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_ex_q   <= idex_ex_d;
      idex_alu_q  <= idex_alu_d;
      idex_m_q    <= idex_m_d;
      idex_wb_q   <= idex_wb_d;
      idex_rt_q   <= idex_rt_d;
      exmem_m_q   <= exmem_m_d;
      exmem_wb_q  <= exmem_wb_d;
      memwb_wb_q  <= memwb_wb_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign illegal    = illegal_q;
  assign idex_ex    = idex_ex_q;
  assign idex_aluop = idex_alu_q;
  assign idex_m     = idex_m_q;
  assign idex_wb    = idex_wb_q;
  assign idex_rt    = idex_rt_q;
  assign exmem_m    = exmem_m_q;
  assign exmem_wb   = exmem_wb_q;
  assign memwb_wb   = memwb_wb_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: three instances (default, EXT_OPS=0, CNT_W=2) share stimulus
// and are compared each cycle against a stage-record model plus hand-computed literals.
module tb_pipe_control_unit;
  typedef struct packed {
    logic [1:0] ex;
    logic [2:0] alu;
    logic [3:0] m;
    logic [1:0] wb;
    logic [4:0] rt;
  } ctl_t;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
  localparam logic [5:0] BEQ = 6'b000100, J_OP = 6'b000010, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, BNE = 6'b000101;

  logic clk = 1'b0;
  logic rst = 1'b1, id_valid = 1'b0, branch_taken = 1'b0;
  logic [5:0] op = 6'b000000;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0;

  logic       st[3], fl[3], jp[3], il[3];
  logic [1:0] iex[3], iwb[3], xwb[3], mwb[3];
  logic [2:0] ialu[3];
  logic [3:0] im[3], xm[3];
  logic [4:0] irt[3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;
  logic [15:0] obs_sc[3], obs_fc[3];

  int total = 0, bad = 0;
  bit cmp_en = 1'b0;
  logic seen_stall, seen_flush, seen_jump, any_stall;

  ctl_t       m_idex[3];
  logic [3:0] m_xm[3];
  logic [1:0] m_xwb[3], m_wb[3];
  logic       m_ill[3];
  int         m_sc[3], m_fc[3];

  always #5 clk = ~clk;

  pipe_control_unit u0 (.clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .id_rs(id_rs), .id_rt(id_rt),
    .branch_taken(branch_taken), .stall(st[0]), .flush(fl[0]), .jump(jp[0]), .illegal(il[0]),
    .idex_ex(iex[0]), .idex_aluop(ialu[0]), .idex_m(im[0]), .idex_wb(iwb[0]), .idex_rt(irt[0]),
    .exmem_m(xm[0]), .exmem_wb(xwb[0]), .memwb_wb(mwb[0]), .stall_cnt(sc0), .flush_cnt(fc0));
  pipe_control_unit #(.EXT_OPS(0)) u1 (.clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .id_rs(id_rs),
    .id_rt(id_rt), .branch_taken(branch_taken), .stall(st[1]), .flush(fl[1]), .jump(jp[1]), .illegal(il[1]),
    .idex_ex(iex[1]), .idex_aluop(ialu[1]), .idex_m(im[1]), .idex_wb(iwb[1]), .idex_rt(irt[1]),
    .exmem_m(xm[1]), .exmem_wb(xwb[1]), .memwb_wb(mwb[1]), .stall_cnt(sc1), .flush_cnt(fc1));
  pipe_control_unit #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .id_rs(id_rs),
    .id_rt(id_rt), .branch_taken(branch_taken), .stall(st[2]), .flush(fl[2]), .jump(jp[2]), .illegal(il[2]),
    .idex_ex(iex[2]), .idex_aluop(ialu[2]), .idex_m(im[2]), .idex_wb(iwb[2]), .idex_rt(irt[2]),
    .exmem_m(xm[2]), .exmem_wb(xwb[2]), .memwb_wb(mwb[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  always_comb begin
    obs_sc[0] = sc0; obs_fc[0] = fc0;
    obs_sc[1] = sc1; obs_fc[1] = fc1;
    obs_sc[2] = {14'd0, sc2}; obs_fc[2] = {14'd0, fc2};
  end

  function automatic bit ext_of(int k);
    return k != 1;
  endfunction

  function automatic int cmax(int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic bit known(logic [5:0] o, bit ext);
    return (o inside {R_OP, LW, SW, ADDI, BEQ, J_OP}) || (ext && (o inside {ANDI, ORI, SLTI, BNE}));
  endfunction

  function automatic bit reads_rt(logic [5:0] o, bit ext);
    return known(o, ext) && (o inside {R_OP, SW, BEQ, BNE});
  endfunction

  // Control table: {reg_dst,alu_src} aluop {bne,beq,mem_read,mem_write} {mem_to_reg,reg_write}
  function automatic ctl_t dec(logic v, logic [5:0] o, logic [4:0] rt, bit ext);
    ctl_t c = '0;
    if (v && known(o, ext) && o != J_OP) begin
      case (o)
        R_OP:    c = '{ex: 2'b10, alu: 3'b010, m: 4'b0000, wb: 2'b01, rt: rt};
        LW:      c = '{ex: 2'b01, alu: 3'b000, m: 4'b0010, wb: 2'b11, rt: rt};
        SW:      c = '{ex: 2'b01, alu: 3'b000, m: 4'b0001, wb: 2'b00, rt: rt};
        ADDI:    c = '{ex: 2'b01, alu: 3'b000, m: 4'b0000, wb: 2'b01, rt: rt};
        BEQ:     c = '{ex: 2'b00, alu: 3'b001, m: 4'b0100, wb: 2'b00, rt: rt};
        ANDI:    c = '{ex: 2'b01, alu: 3'b011, m: 4'b0000, wb: 2'b01, rt: rt};
        ORI:     c = '{ex: 2'b01, alu: 3'b100, m: 4'b0000, wb: 2'b01, rt: rt};
        SLTI:    c = '{ex: 2'b01, alu: 3'b101, m: 4'b0000, wb: 2'b01, rt: rt};
        BNE:     c = '{ex: 2'b00, alu: 3'b001, m: 4'b1000, wb: 2'b00, rt: rt};
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  function automatic bit mhz(int k);
    return m_idex[k].m[1] && m_idex[k].rt != 5'd0 && id_valid &&
           (m_idex[k].rt == id_rs || (reads_rt(op, ext_of(k)) && m_idex[k].rt == id_rt));
  endfunction

  function automatic int sat(int x, int k);
    return (x < cmax(k)) ? x + 1 : x;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut%0d): got=%0h want=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_idex[k] = '0; m_xm[k] = 4'b0; m_xwb[k] = 2'b0; m_wb[k] = 2'b0; m_ill[k] = 1'b0;
      m_sc[k] = 0; m_fc[k] = 0;
    end
  end

  // Model advance: stage records move by the priority rules of rst, branch, hazard, normal
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_idex[k] <= '0; m_xm[k] <= 4'b0; m_xwb[k] <= 2'b0; m_wb[k] <= 2'b0;
        m_ill[k] <= 1'b0; m_sc[k] <= 0; m_fc[k] <= 0;
      end else begin
        m_wb[k]  <= m_xwb[k];
        m_ill[k] <= id_valid && !known(op, ext_of(k)) && !branch_taken && !mhz(k);
        if (branch_taken) begin
          m_idex[k] <= '0; m_xm[k] <= 4'b0; m_xwb[k] <= 2'b0; m_fc[k] <= sat(m_fc[k], k);
        end else if (mhz(k)) begin
          m_idex[k] <= '0; m_xm[k] <= m_idex[k].m; m_xwb[k] <= m_idex[k].wb; m_sc[k] <= sat(m_sc[k], k);
        end else begin
          m_idex[k] <= dec(id_valid, op, id_rt, ext_of(k));
          m_xm[k] <= m_idex[k].m; m_xwb[k] <= m_idex[k].wb;
          if (id_valid && op == J_OP) m_fc[k] <= sat(m_fc[k], k);
        end
      end
    end
  end

  // Per-cycle comparison of every output of every instance against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("stall", k, st[k], !rst && !branch_taken && mhz(k));
        chk("flush", k, fl[k], !rst && (branch_taken || (!mhz(k) && id_valid && op == J_OP)));
        chk("jump", k, jp[k], id_valid && op == J_OP);
        chk("illegal", k, il[k], m_ill[k]);
        chk("idex_ex", k, iex[k], m_idex[k].ex);
        chk("idex_aluop", k, ialu[k], m_idex[k].alu);
        chk("idex_m", k, im[k], m_idex[k].m);
        chk("idex_wb", k, iwb[k], m_idex[k].wb);
        chk("idex_rt", k, irt[k], m_idex[k].rt);
        chk("exmem_m", k, xm[k], m_xm[k]);
        chk("exmem_wb", k, xwb[k], m_xwb[k]);
        chk("memwb_wb", k, mwb[k], m_wb[k]);
        chk("stall_cnt", k, obs_sc[k], m_sc[k]);
        chk("flush_cnt", k, obs_fc[k], m_fc[k]);
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [5:0] o, input logic [4:0] rs,
                     input logic [4:0] rt, input logic bt);
    rst = r; id_valid = v; op = o; id_rs = rs; id_rt = rt; branch_taken = bt;
    @(negedge clk);
    seen_stall = st[0]; seen_flush = fl[0]; seen_jump = jp[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b1, 1'b0, R_OP, 5'd0, 5'd0, 1'b0);
    cmp_en = 1'b1;
    chk("lit_reset_idex_wb", 0, iwb[0], 2'b00);
    chk("lit_reset_stall_cnt", 0, obs_sc[0], 16'd0);
    chk("lit_reset_illegal", 0, il[0], 1'b0);

    any_stall = 1'b0;
    cyc(1'b0, 1'b1, LW, 5'd1, 5'd2, 1'b0);   any_stall |= seen_stall;
    chk("lit_lw_idex_wb", 0, iwb[0], 2'b11);
    chk("lit_lw_idex_ex", 0, iex[0], 2'b01);
    cyc(1'b0, 1'b1, ADDI, 5'd3, 5'd4, 1'b0); any_stall |= seen_stall;
    chk("lit_lw_exmem_m", 0, xm[0], 4'b0010);
    cyc(1'b0, 1'b1, SW, 5'd6, 5'd7, 1'b0);   any_stall |= seen_stall;
    chk("lit_lw_memwb_wb", 0, mwb[0], 2'b11);
    cyc(1'b0, 1'b1, R_OP, 5'd8, 5'd9, 1'b0); any_stall |= seen_stall;
    cyc(1'b0, 1'b0, R_OP, 5'd0, 5'd0, 1'b0); any_stall |= seen_stall;
    chk("lit_stream_no_stall", 0, any_stall, 1'b0);

    cyc(1'b0, 1'b1, LW, 5'd1, 5'd5, 1'b0);
    cyc(1'b0, 1'b1, R_OP, 5'd5, 5'd3, 1'b0);
    chk("lit_loaduse_stall", 0, seen_stall, 1'b1);
    chk("lit_loaduse_bubble", 0, {iex[0], ialu[0], im[0], iwb[0], irt[0]}, 16'd0);
    chk("lit_loaduse_stall_cnt", 0, obs_sc[0], 16'd1);
    cyc(1'b0, 1'b1, R_OP, 5'd5, 5'd3, 1'b0);
    chk("lit_loaduse_release", 0, seen_stall, 1'b0);
    chk("lit_loaduse_r_wb", 0, iwb[0], 2'b01);
    chk("lit_loaduse_r_ex", 0, iex[0], 2'b10);

    cyc(1'b0, 1'b1, LW, 5'd1, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, R_OP, 5'd0, 5'd0, 1'b0);
    chk("lit_rt0_no_stall", 0, seen_stall, 1'b0);

    cyc(1'b0, 1'b1, BEQ, 5'd1, 5'd2, 1'b0);
    cyc(1'b0, 1'b1, LW, 5'd1, 5'd6, 1'b0);
    cyc(1'b0, 1'b1, R_OP, 5'd6, 5'd1, 1'b1);
    chk("lit_branch_flush", 0, seen_flush, 1'b1);
    chk("lit_branch_no_stall", 0, seen_stall, 1'b0);
    chk("lit_branch_kill", 0, {im[0], iwb[0], xm[0], xwb[0]}, 12'd0);
    chk("lit_branch_flush_cnt", 0, obs_fc[0], 16'd1);
    chk("lit_branch_stall_cnt", 0, obs_sc[0], 16'd1);

    cyc(1'b0, 1'b1, J_OP, 5'd0, 5'd0, 1'b0);
    chk("lit_j_jump", 0, seen_jump, 1'b1);
    chk("lit_j_flush", 0, seen_flush, 1'b1);
    chk("lit_j_bubble", 0, {iex[0], ialu[0], im[0], iwb[0], irt[0]}, 16'd0);
    cyc(1'b0, 1'b1, ADDI, 5'd1, 5'd2, 1'b0);
    chk("lit_j_addi_wb", 0, iwb[0], 2'b01);
    chk("lit_j_flush_cnt", 0, obs_fc[0], 16'd2);

    cyc(1'b0, 1'b1, ORI, 5'd1, 5'd3, 1'b0);
    chk("lit_ori_aluop", 0, ialu[0], 3'b100);
    chk("lit_ori_legal", 0, il[0], 1'b0);
    chk("lit_ori_illegal_noext", 1, il[1], 1'b1);
    chk("lit_ori_bubble_noext", 1, {iex[1], ialu[1], im[1], iwb[1], irt[1]}, 16'd0);

    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, LW, 5'd5, 5'd5, 1'b0);
    chk("lit_sat_stall_cnt", 2, obs_sc[2], 16'd3);
    chk("lit_wide_stall_cnt", 0, obs_sc[0], 16'd6);

    cyc(1'b0, 1'b1, LW, 5'd1, 5'd2, 1'b0);
    cyc(1'b1, 1'b1, ADDI, 5'd2, 5'd4, 1'b0);
    chk("lit_rst_no_stall", 0, seen_stall, 1'b0);
    chk("lit_rst_no_flush", 0, seen_flush, 1'b0);
    chk("lit_rst_cnts", 0, {obs_sc[0], obs_fc[0]}, 32'd0);
    chk("lit_rst_pipe", 0, {iwb[0], im[0], xm[0], xwb[0], mwb[0], il[0]}, 15'd0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, R_OP, 5'd0, 5'd0, 1'b0);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
